// File: rtl/wb_initiator_bridge.sv
// Valid/ready request port to single-outstanding Wishbone B4 pipelined initiator.
// Handles responder stall and aborts with an error response after TIMEOUT_CYCLES of cyc.
module wb_initiator_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    // Request side: a request transfers at an edge where req_valid && req_ready.
    // The requester holds its fields stable while req_valid is high and req_ready is low.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_sel,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_dat,
    output logic        rsp_valid,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   cyc_q;
    logic                   stb_q;
    logic                   we_q;
    logic [3:0]             sel_q;
    logic [31:0]            adr_q;
    logic [31:0]            dat_q;
    logic                   rsp_valid_q;
    logic                   rsp_err_q;
    logic [31:0]            rsp_dat_q;

    logic                   busy;
    logic                   ack_hit;
    logic                   timeout_hit;

    assign busy = (state_q == ISSUE) || (state_q == WAIT);

    // An ack only counts once the strobe has actually been taken (not stalled).
    assign ack_hit = ((state_q == ISSUE) && !wb_stall_i && wb_ack_i) ||
                     ((state_q == WAIT) && wb_ack_i);

    assign timeout_hit = busy && !ack_hit && (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES));

    assign req_ready = (state_q == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= 32'h0;
            dat_q       <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= 32'h0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (busy) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        sel_q   <= req_sel;
                        adr_q   <= req_adr;
                        dat_q   <= req_dat;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        cnt_q   <= CNT_WIDTH'(1);
                        state_q <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (ack_hit) begin
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_dat_q   <= we_q ? 32'h0 : wb_dat_i;
                        state_q     <= IDLE;
                    end else if (timeout_hit) begin
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_dat_q   <= 32'h0;
                        state_q     <= IDLE;
                    end else if ((state_q == ISSUE) && !wb_stall_i) begin
                        stb_q   <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                default: begin
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = stb_q;
    assign wb_we_o     = we_q;
    assign wb_sel_o    = sel_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_dat     = rsp_dat_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_initiator_bridge.sv
// Self-checking bench for wb_initiator_bridge: vector table of single transactions
// plus hand-written back-to-back, reset-abort and spurious-ack sequences.
module tb_wb_initiator_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_sel;
    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_stall_i;
    logic [1:0]  dbg_state_o;

    wb_initiator_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_sel(req_sel), .req_adr(req_adr), .req_dat(req_dat),
        .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i),
        .dbg_state_o(dbg_state_o)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdata;
        int          stall;    // cycles of cyc during which stb is stalled
        int          ack_at;   // cyc-cycle index carrying ack, -1 = never
        logic        exp_err;
        logic [31:0] exp_dat;
        int          exp_cyc;
        int          exp_stb;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          rsp_count = 0;
    logic [32:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every response pulse pops one expected {err,dat}
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            logic [32:0] e;
            rsp_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
                check("rsp_dat", rsp_dat, e[31:0]);
            end
        end
    end

    // Entered #1 after a posedge; returns #1 after a posedge.
    task automatic run_txn(input string name, input vec_t v);
        int   cyc_cnt, stb_cnt, c, pulses0;
        logic stable;
        req_we    = v.we;
        req_sel   = v.sel;
        req_adr   = v.adr;
        req_dat   = v.dat;
        req_valid = 1'b1;
        check({name, ":req_ready_idle"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_adr   = $urandom;
        exp_q.push_back({v.exp_err, v.exp_dat});
        pulses0 = rsp_count;
        cyc_cnt = 0; stb_cnt = 0; c = 0; stable = 1'b1;
        while (wb_cyc_o === 1'b1 && c < 100) begin
            cyc_cnt++;
            if (wb_stb_o) stb_cnt++;
            if (wb_we_o !== v.we || wb_sel_o !== v.sel || wb_adr_o !== v.adr || wb_dat_o !== v.dat)
                stable = 1'b0;
            check({name, ":req_ready_busy"}, {31'd0, req_ready}, 32'd0);
            wb_stall_i = wb_stb_o && (c < v.stall);
            wb_ack_i   = (v.ack_at >= 0) && (c == v.ack_at);
            wb_dat_i   = wb_ack_i ? v.rdata : $urandom;
            @(posedge clk); #1;
            c++;
        end
        wb_ack_i   = 1'b0;
        wb_stall_i = 1'b0;
        check({name, ":bounded"}, {31'd0, c < 100}, 32'd1);
        check({name, ":cyc_cycles"}, cyc_cnt, v.exp_cyc);
        check({name, ":stb_cycles"}, stb_cnt, v.exp_stb);
        check({name, ":fields_stable"}, {31'd0, stable}, 32'd1);
        check({name, ":rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({name, ":req_ready_rsp"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        check({name, ":rsp_pulse_drop"}, {31'd0, rsp_valid}, 32'd0);
        check({name, ":rsp_err_hold"}, {31'd0, rsp_err}, {31'd0, v.exp_err});
        check({name, ":rsp_dat_hold"}, rsp_dat, v.exp_dat);
        check({name, ":one_pulse"}, rsp_count - pulses0, 32'd1);
    endtask

    vec_t vecs[8];

    initial begin
        logic [31:0] w_sel;
        int p0;
        // name-free table: one vector per scenario
        vecs[0] = '{1'b0, 4'hF, 32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 0, 1,  1'b0, 32'hDEAD_BEEF, 2, 1};
        vecs[1] = '{1'b1, 4'h1, 32'h0201_0000, 32'h0000_00A5, 32'hFFFF_FFFF, 3, 3,  1'b0, 32'h0,         4, 4};
        vecs[2] = '{1'b0, 4'hF, 32'h0300_0000, 32'h0,         32'h0,         0, -1, 1'b1, 32'h0,         TO, 1};
        vecs[3] = '{1'b0, 4'hF, 32'h0300_0004, 32'h0,         32'h1234_5678, 0, TO-1, 1'b0, 32'h1234_5678, TO, 1};
        vecs[4] = '{1'b0, 4'h3, 32'h1000_0002, 32'h0,         32'hCAFE_F00D, 0, 0,  1'b0, 32'hCAFE_F00D, 1, 1};
        vecs[5] = '{1'b0, 4'hF, 32'h2000_0000, 32'h0,         32'h0,         20, -1, 1'b1, 32'h0,        TO, TO};
        vecs[6] = '{1'b0, 4'hF, 32'h2000_0008, 32'h0,         32'h5555_AAAA, 2, 1,  1'b1, 32'h0,         TO, 3};
        w_sel = $urandom_range(1, 15);
        vecs[7] = '{1'b1, w_sel[3:0], $urandom, $urandom,     32'h0BAD_0BAD, 1, 2,  1'b0, 32'h0,         3, 2};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_sel = 4'h0; req_adr = 32'h0;
        req_dat = 32'h0; wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_stall_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst:cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("rst:stb", {31'd0, wb_stb_o}, 32'd0);
        check("rst:rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst:req_ready", {31'd0, req_ready}, 32'd0);
        check("rst:outs", {wb_adr_o | wb_dat_o | rsp_dat}, 32'h0);
        check("rst:ctl", {26'd0, wb_we_o, wb_sel_o, rsp_err}, 32'h0);
        rst = 1'b0;
        #1;
        check("rst:req_ready_release", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i]);
            @(posedge clk); #1;
        end

        // Back-to-back: second request held on req_valid while the first is in flight
        p0 = rsp_count;
        req_we = 1'b0; req_sel = 4'hF; req_adr = 32'h4000_0000; req_valid = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 32'h1111_1111});
        req_adr = 32'h4000_0004;
        check("b2b:stb_first", {31'd0, wb_stb_o}, 32'd1);
        check("b2b:busy_not_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        wb_ack_i = 1'b1; wb_dat_i = 32'h1111_1111;
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        check("b2b:rsp1", {31'd0, rsp_valid}, 32'd1);
        check("b2b:ready_in_rsp", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 32'h2222_2222});
        req_valid = 1'b0;
        check("b2b:stb_second", {31'd0, wb_stb_o}, 32'd1);
        check("b2b:adr_second", wb_adr_o, 32'h4000_0004);
        @(posedge clk); #1;
        wb_ack_i = 1'b1; wb_dat_i = 32'h2222_2222;
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        check("b2b:rsp2", {31'd0, rsp_valid}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("b2b:two_pulses", rsp_count - p0, 32'd2);

        // Reset during WAIT aborts silently; a later ack is ignored
        p0 = rsp_count;
        req_adr = 32'h5000_0000; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rstmid:in_wait", {30'd0, dbg_state_o}, 32'd2);
        rst = 1'b1;
        #1;
        check("rstmid:ready_in_rst", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid:cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        check("rstmid:no_rsp", {31'd0, rsp_valid}, 32'd0);
        wb_ack_i = 1'b1; wb_dat_i = 32'h7777_7777;
        #1;
        check("rstmid:ready_after", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        check("rstmid:late_ack_rsp", {31'd0, rsp_valid}, 32'd0);
        check("rstmid:late_ack_cyc", {31'd0, wb_cyc_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rstmid:no_pulses", rsp_count - p0, 32'd0);

        // Spurious ack while idle
        wb_ack_i = 1'b1;
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        check("idle_ack:rsp", {31'd0, rsp_valid}, 32'd0);
        check("idle_ack:state", {30'd0, dbg_state_o}, 32'd0);

        repeat (2) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
